// File: rtl/cmp_arbiter.sv
// Two-requester round-robin front end for a shared signed compare datapath.
// Grant, flag and result steps each take one registered cycle.
module cmp_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [1:0]       cfn0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [1:0]       cfn1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] cmp,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    FLAGS,
    RESULT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic             take;
  logic             win;
  logic             gnt;
  logic             last_grant;
  logic [WIDTH-1:0] a_l;
  logic [WIDTH-1:0] b_l;
  logic [1:0]       cfn_l;
  logic [WIDTH-1:0] diff;
  logic             z;
  logic             n;
  logic             v;
  logic             res;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Contention goes to whoever did not win last time.
  always_comb begin
    state_nx = state;
    take     = 1'b0;
    win      = 1'b0;
    unique case (state)
      IDLE: begin
        take = req0 | req1;
        win  = (req0 & req1) ? ~last_grant : req1;
        if (take) state_nx = FLAGS;
      end
      FLAGS:   state_nx = RESULT;
      RESULT:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign diff = a_l - b_l;
  assign busy = (state != IDLE);

  always_comb begin
    res = 1'b0;
    unique case (cfn_l)
      2'b01:   res = z;
      2'b10:   res = n ^ v;
      2'b11:   res = z | (n ^ v);
      default: res = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      cmp        <= '0;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      a_l        <= '0;
      b_l        <= '0;
      cfn_l      <= 2'b00;
      z          <= 1'b0;
      n          <= 1'b0;
      v          <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      if (take) begin
        gnt        <= win;
        last_grant <= win;
        a_l        <= win ? a1 : a0;
        b_l        <= win ? b1 : b0;
        cfn_l      <= win ? cfn1 : cfn0;
      end
      if (state == FLAGS) begin
        z <= (diff == '0);
        n <= diff[WIDTH-1];
        v <= (a_l[WIDTH-1] & ~b_l[WIDTH-1] & ~diff[WIDTH-1])
           | (~a_l[WIDTH-1] & b_l[WIDTH-1] & diff[WIDTH-1]);
      end
      if (state == RESULT) begin
        cmp  <= {{(WIDTH-1){1'b0}}, res};
        ack0 <= ~gnt;
        ack1 <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_cmp_arbiter.sv
// Self-checking bench for cmp_arbiter: directed cases plus random traffic
// checked against a signed-compare / round-robin reference model.
module tb_cmp_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         req0;
  logic [W-1:0] a0;
  logic [W-1:0] b0;
  logic [1:0]   cfn0;
  logic         req1;
  logic [W-1:0] a1;
  logic [W-1:0] b1;
  logic [1:0]   cfn1;
  logic         ack0;
  logic         ack1;
  logic [W-1:0] cmp;
  logic         busy;

  int errors = 0;
  int checks = 0;
  logic last;

  cmp_arbiter #(.WIDTH(W)) dut (
    .clk  (clk),
    .reset(reset),
    .req0 (req0),
    .a0   (a0),
    .b0   (b0),
    .cfn0 (cfn0),
    .req1 (req1),
    .a1   (a1),
    .b1   (b1),
    .cfn1 (cfn1),
    .ack0 (ack0),
    .ack1 (ack1),
    .cmp  (cmp),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_cmp(input logic [W-1:0] a,
                                           input logic [W-1:0] b,
                                           input logic [1:0] f);
    logic r;
    case (f)
      2'b01:   r = (a == b);
      2'b10:   r = ($signed(a) < $signed(b));
      2'b11:   r = ($signed(a) <= $signed(b));
      default: r = 1'b0;
    endcase
    return {{(W-1){1'b0}}, r};
  endfunction

  // Called #1 after an edge with the DUT idle (or in its ack cycle).
  task automatic txn(input logic r0, input logic r1,
                     input logic [W-1:0] xa0, input logic [W-1:0] xb0,
                     input logic [1:0] xc0,
                     input logic [W-1:0] xa1, input logic [W-1:0] xb1,
                     input logic [1:0] xc1,
                     input bit keep, input bit mut);
    int nc;
    logic w;
    logic [W-1:0] exp;
    req0 = r0; a0 = xa0; b0 = xb0; cfn0 = xc0;
    req1 = r1; a1 = xa1; b1 = xb1; cfn1 = xc1;
    w    = (r0 && r1) ? ~last : r1;
    last = w;
    exp  = w ? ref_cmp(xa1, xb1, xc1) : ref_cmp(xa0, xb0, xc0);
    nc   = 0;
    do begin
      @(posedge clk); #1;
      nc++;
      if (nc < 3) check("busy", {31'b0, busy}, 1);
      if (mut && nc == 1) begin
        a0 = 9; a1 = ~xa1; b1 = ~xb1;
      end
    end while (!(ack0 | ack1) && nc < 8);
    check("latency", nc, 3);
    check("ack0", {31'b0, ack0}, {31'b0, ~w});
    check("ack1", {31'b0, ack1}, {31'b0, w});
    check("cmp", cmp, exp);
    if (!keep) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick();
    logic [W-1:0] corner [4];
    corner[0] = 32'h8000_0000;
    corner[1] = 32'h7FFF_FFFF;
    corner[2] = 32'h0;
    corner[3] = 32'hFFFF_FFFF;
    if ($urandom_range(0, 1) == 0) return corner[$urandom_range(0, 3)];
    return $urandom;
  endfunction

  initial begin
    reset = 1'b1;
    req0 = 0; a0 = 0; b0 = 0; cfn0 = 0;
    req1 = 0; a1 = 0; b1 = 0; cfn1 = 0;
    last = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack0", {31'b0, ack0}, 0);
    check("rst_ack1", {31'b0, ack1}, 0);
    check("rst_cmp", cmp, 0);
    check("rst_busy", {31'b0, busy}, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    txn(1, 0, 5, 5, 2'b01, 0, 0, 0, 0, 0);
    check("idle_busy", {31'b0, busy}, 0);
    txn(0, 1, 0, 0, 0, 32'hFFFF_FFFF, 1, 2'b10, 0, 0);
    txn(0, 1, 0, 0, 0, 1, 32'hFFFF_FFFF, 2'b10, 0, 0);
    txn(1, 0, 32'h8000_0000, 1, 2'b11, 0, 0, 0, 0, 0);
    txn(1, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 2'b10, 0, 0, 0, 0, 0);

    for (int i = 0; i < 4; i++)
      txn(1, 1, 7, 7, 2'b01, 3, 8, 2'b11, (i < 3), 0);
    txn(1, 1, 4, 4, 2'b00, 4, 4, 2'b00, 1, 0);
    txn(1, 1, 4, 4, 2'b00, 4, 4, 2'b00, 0, 0);

    txn(1, 0, 5, 5, 2'b01, 0, 0, 0, 0, 1);

    // Abort in FLAGS; cmp from the previous result is 1 here.
    req0 = 1; a0 = 2; b0 = 2; cfn0 = 2'b01;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("abort_ack0", {31'b0, ack0}, 0);
    check("abort_cmp", cmp, 0);
    check("abort_busy", {31'b0, busy}, 0);
    @(posedge clk); #1;
    check("abort_ack0b", {31'b0, ack0}, 0);
    reset = 1'b0;
    last = 1'b1;
    txn(1, 0, 2, 2, 2'b01, 0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      int rs;
      logic [W-1:0] x;
      rs = $urandom_range(1, 3);
      x  = pick();
      txn(rs[0], rs[1],
          x, ($urandom_range(0, 3) == 0) ? x : pick(),
          2'($urandom), pick(), pick(), 2'($urandom),
          ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
      if (req0 | req1) begin
        req0 = 1'b0;
        req1 = 1'b0;
        @(posedge clk); #1;
        check("rand_idle", {31'b0, ack0 | ack1 | busy}, 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
